// File: rtl/capture_buffer.sv
// Arm/trigger capture of a sample stream into a circular RAM, then readout of
// the captured window (oldest first) over a valid/ready port.
// Handshake: a word moves when out_valid & out_ready are both high on a rising
// edge; while out_valid is high and out_ready low, out_data/out_last/out_valid hold.
module capture_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  trigger,
   input  logic [ADDR_WIDTH-1:0] post_count,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  done,
   output logic [1:0]            state
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_POST    = 2'd2,
      S_READOUT = 2'd3
   } state_t;

   state_t cur_state, nxt_state;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] ram_q;
   logic [DATA_WIDTH-1:0] skid_data;
   logic [ADDR_WIDTH-1:0] wr_ptr, remaining, rd_addr, rd_start;
   logic [ADDR_WIDTH:0]   fill, rd_cnt;
   logic [1:0]            occ_after;
   logic                  wr_en, rd_en, rd_is_last, xfer;
   logic                  rd_pending, rd_pending_last, skid_valid, skid_last;

   always_ff @(posedge clk) begin
      if (reset) cur_state <= S_IDLE;
      else       cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_IDLE:    if (arm) nxt_state = S_ARMED;
         S_ARMED:   if (in_valid && trigger)
                       nxt_state = (post_count == '0) ? S_READOUT : S_POST;
         S_POST:    if (in_valid && remaining == ADDR_WIDTH'(1)) nxt_state = S_READOUT;
         S_READOUT: if (xfer && out_last) nxt_state = S_IDLE;
         default:   nxt_state = S_IDLE;
      endcase
   end

   // Reads are issued ahead so that the output register plus skid register plus
   // the in-flight RAM read never hold more than two words.
   always_comb begin
      state      = cur_state;
      wr_en      = in_valid && (cur_state == S_ARMED || cur_state == S_POST);
      xfer       = out_valid && out_ready;
      rd_start   = (fill == FULL) ? wr_ptr : '0;
      rd_addr    = rd_start + rd_cnt[ADDR_WIDTH-1:0];
      occ_after  = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pending} - {1'b0, xfer};
      rd_en      = (cur_state == S_READOUT) && (rd_cnt < fill) && (occ_after < 2'd2);
      rd_is_last = (rd_cnt == fill - (ADDR_WIDTH+1)'(1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         fill      <= '0;
         remaining <= '0;
      end else begin
         if (cur_state == S_IDLE && arm) begin
            wr_ptr <= '0;
            fill   <= '0;
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (fill != FULL) fill <= fill + (ADDR_WIDTH+1)'(1);
         end
         if (cur_state == S_ARMED && in_valid && trigger)
            remaining <= post_count;
         else if (cur_state == S_POST && in_valid)
            remaining <= remaining - ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data;
      if (rd_en) ram_q <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt          <= '0;
         rd_pending      <= 1'b0;
         rd_pending_last <= 1'b0;
         skid_valid      <= 1'b0;
         skid_last       <= 1'b0;
         skid_data       <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_last        <= 1'b0;
         done            <= 1'b0;
      end else begin
         done            <= 1'b0;
         rd_pending      <= rd_en;
         rd_pending_last <= rd_is_last;
         if (rd_en) rd_cnt <= rd_cnt + (ADDR_WIDTH+1)'(1);
         if (cur_state != S_READOUT) begin
            rd_cnt     <= '0;
            skid_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
         end else if (xfer && out_last) begin
            rd_cnt     <= '0;
            skid_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b1;
         end else if (!out_valid || xfer) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_data   <= skid_data;
               out_last   <= skid_last;
               skid_valid <= rd_pending;
               skid_data  <= ram_q;
               skid_last  <= rd_pending_last;
            end else if (rd_pending) begin
               out_valid <= 1'b1;
               out_data  <= ram_q;
               out_last  <= rd_pending_last;
            end else begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         end else if (rd_pending) begin
            // Output is stalled: park the arriving word in the skid register.
            skid_valid <= 1'b1;
            skid_data  <= ram_q;
            skid_last  <= rd_pending_last;
         end
      end
   end

endmodule
